// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed 4-digit seven-segment driver with
// anti-ghosting blanking, decimal-point placement and lap-hold freeze.
module seg_display_mux #(
  parameter int         REFRESH_DIV  = 100000,
  parameter int         BLANK_CYCLES = 1000,
  parameter logic [3:0] DP_MASK      = 4'b0101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic       dot,
  input  logic       lap,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       held
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          hold_q, hold_d, s1_q, s2_q, s3_q, rise, wrap, blank;
  logic [6:0]    frz_q [4];
  logic [6:0]    live, pat;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  always_comb begin
    wrap    = presc_q == PW'(REFRESH_DIV - 1);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    rise    = s2_q & ~s3_q;
    hold_d  = hold_q ^ rise;
    live    = idx_q == 2'd0 ? seg1 : idx_q == 2'd1 ? seg2 : idx_q == 2'd2 ? seg3 : seg4;
    pat     = hold_q ? frz_q[idx_q] : live;
    blank   = presc_q < PW'(BLANK_CYCLES);
    an_d    = blank ? 4'hF : ~(4'b1000 >> idx_q);
    seg_d   = blank ? 7'h7F : ~pat;
    dp_d    = blank | ~(dot & DP_MASK[idx_q]);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      frz_q   <= '{default: '0};
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      s1_q    <= lap;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      // Capture only on the press that enters hold; the release press keeps the old snapshot.
      if (rise && !hold_q) frz_q <= '{seg1, seg2, seg3, seg4};
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign held = hold_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed stimulus with a per-cycle scoreboard of
// expected outputs plus constant checks taken from the display tables.
module tb_seg_display_mux;
  localparam int         RD = 8;
  localparam int         BC = 2;
  localparam logic [3:0] DM = 4'b0101;
  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp; logic held;} out_t;
  logic       clk = 1'b0, reset = 1'b0, dot = 1'b0, lap = 1'b0;
  logic [6:0] sg [4];
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, held;
  int         passed = 0, total = 0;
  out_t       sb[$];
  int         m_p, m_i;
  logic       m_h, m1, m2, m3;
  logic [6:0] mf [4];
  logic [3:0] t_an [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] t_seg [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

  seg_display_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DP_MASK(DM)) dut (
    .clk(clk), .reset(reset), .seg1(sg[0]), .seg2(sg[1]), .seg3(sg[2]), .seg4(sg[3]),
    .dot(dot), .lap(lap), .an(an), .seg(seg), .dp(dp), .held(held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    out_t       e;
    logic       r, nh;
    logic [6:0] p;
    if (!reset) begin
      e = '{4'hF, 7'h7F, 1'b1, 1'b0};
      m_p = 0; m_i = 0; m_h = 0; m1 = 0; m2 = 0; m3 = 0;
      foreach (mf[i]) mf[i] = '0;
    end else begin
      r  = m2 & ~m3;
      nh = m_h ^ r;
      p  = m_h ? mf[m_i] : sg[m_i];
      if (m_p < BC) e = '{4'hF, 7'h7F, 1'b1, nh};
      else e = '{~(4'b0001 << (3 - m_i)), ~p, ~(dot & DM[m_i]), nh};
      if (r && !m_h) foreach (mf[i]) mf[i] = sg[i];
      m_h = nh; m3 = m2; m2 = m1; m1 = lap;
      if (m_p == RD - 1) begin m_p = 0; m_i = (m_i + 1) % 4; end
      else m_p++;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    out_t e;
    @(posedge clk);
    model_edge();
    #1;
    e = sb.pop_front();
    chk("an", an, e.an);
    chk("seg", seg, e.seg);
    chk("dp", dp, e.dp);
    chk("held", held, e.held);
  endtask

  initial begin
    int n;
    sg = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    repeat (3) tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (an == 4'b0111) break;
    end
    chk("first_active_latency", n, 3);
    repeat (40) begin
      tick();
      for (int k = 0; k < 4; k++) if (an == t_an[k]) chk("slot_seg", seg, t_seg[k]);
    end
    dot = 1'b1;
    repeat (40) begin
      tick();
      chk("dp_pos", dp, !(an == 4'b0111 || an == 4'b1101));
    end
    dot = 1'b0;
    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
    chk("held_k1", held, 1'b0);
    tick();
    chk("held_k2", held, 1'b1);
    sg[0] = 7'h06;
    repeat (24) begin
      tick();
      if (an == 4'b0111) chk("frozen_seg", seg, 7'h40);
    end
    lap = 1'b1;
    tick();
    lap = 1'b0;
    repeat (2) tick();
    chk("released", held, 1'b0);
    repeat (24) begin
      tick();
      if (an == 4'b0111) chk("live_seg", seg, 7'h79);
    end
    lap = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i >= 2) chk("lap_long", held, 1'b1);
    end
    lap = 1'b0;
    repeat (10) tick();
    chk("lap_long_after", held, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("midrst_held", held, 1'b0);
    chk("midrst_an", an, 4'hF);
    repeat (2) tick();
    reset = 1'b1;
    repeat (20) begin
      tick();
      if (an == 4'b0111) chk("post_rst_live", seg, 7'h79);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
